// File: rtl/rd_empty_fwft_pkg.sv
// Shared FIFO helpers: Gray/binary pointer conversion used by both the
// read-side empty logic and the write-side full logic.
package fifo_pkg;

  localparam int FIFO_PTR_WIDTH = 8;
  localparam int DATA_DEPTH     = 1 << FIFO_PTR_WIDTH;

  // Conversions run on a wide word; callers size-cast to their pointer width,
  // which is exact because leading zeros map to leading zeros both ways.
  localparam int MAX_PTR_BITS = 32;
  typedef logic [MAX_PTR_BITS-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[MAX_PTR_BITS-1] = g[MAX_PTR_BITS-1];
    for (int i = MAX_PTR_BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_empty_fwft_if.sv
// Consumer-facing FWFT read port: pop request plus head-of-queue data and status.
interface rd_empty_fwft_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PTR_WIDTH  = FIFO_PTR_WIDTH
);
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [PTR_WIDTH+1:0]  rd_level;

  // master: the FIFO read side; slave: the consumer
  modport master (
    input  rd_en,
    output dout, dout_valid, empty, almost_empty, rd_level
  );

  modport slave (
    output rd_en,
    input  dout, dout_valid, empty, almost_empty, rd_level
  );
endinterface

// File: rtl/rd_empty_fwft_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
module ptr_sync #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/rd_empty_fwft.sv
// Async FIFO read side: synchronizes the write pointer, fetches from a 1-cycle
// latency memory and presents first-word-fall-through data via out + skid registers.
module rd_empty_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int PTR_WIDTH        = 8,
  parameter int ALMOST_EMPTY_GAP = 3,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [PTR_WIDTH:0]    w_ptr_gray,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_rd_en,
  output logic [PTR_WIDTH-1:0]  rd_addr,
  output logic [PTR_WIDTH:0]    rd_ptr_gray,
  rd_empty_fwft_if.master       rd_if
);

  localparam int PW = PTR_WIDTH + 1;
  localparam int LW = PTR_WIDTH + 2;

  logic [PTR_WIDTH:0]    w2r_gray, w2r_bin, mem_level;
  logic [PTR_WIDTH:0]    rd_ptr_reg, rd_ptr_next, rd_ptr_gray_reg;
  logic                  out_vld_reg, out_vld_next;
  logic                  skid_vld_reg, skid_vld_next;
  logic                  inflight_reg;
  logic [DATA_WIDTH-1:0] out_q_reg, out_q_next;
  logic [DATA_WIDTH-1:0] skid_q_reg, skid_q_next;
  logic                  pop, mem_empty, out_free;
  logic [1:0]            occ;
  logic [LW-1:0]         level;

  ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_w2r_sync (
    .clk (rd_clk),
    .rst (rd_rst),
    .d   (w_ptr_gray),
    .q   (w2r_gray)
  );

  assign w2r_bin   = PW'(gray2bin(ptr_word_t'(w2r_gray)));
  assign mem_empty = (rd_ptr_gray_reg == w2r_gray);
  assign mem_level = w2r_bin - rd_ptr_reg;

  assign pop      = rd_if.rd_en & out_vld_reg;
  assign out_free = ~out_vld_reg | pop;
  assign occ      = 2'(out_vld_reg) + 2'(skid_vld_reg) + 2'(inflight_reg);

  // Never let out + skid + in-flight exceed two words after this cycle's pop.
  assign mem_rd_en   = ~mem_empty & ((occ - 2'(pop)) < 2'd2);
  assign rd_ptr_next = rd_ptr_reg + PW'(mem_rd_en);

  always_comb begin
    out_vld_next  = out_vld_reg;
    out_q_next    = out_q_reg;
    skid_vld_next = skid_vld_reg;
    skid_q_next   = skid_q_reg;
    if (out_free) begin
      if (skid_vld_reg) begin
        // Older skid word goes first; an arriving word takes its place.
        out_vld_next  = 1'b1;
        out_q_next    = skid_q_reg;
        skid_vld_next = inflight_reg;
        if (inflight_reg) begin
          skid_q_next = mem_rd_data;
        end
      end else if (inflight_reg) begin
        out_vld_next = 1'b1;
        out_q_next   = mem_rd_data;
      end else begin
        out_vld_next = 1'b0;
      end
    end else if (inflight_reg) begin
      skid_vld_next = 1'b1;
      skid_q_next   = mem_rd_data;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr_reg      <= '0;
      rd_ptr_gray_reg <= '0;
      out_vld_reg     <= 1'b0;
      skid_vld_reg    <= 1'b0;
      inflight_reg    <= 1'b0;
      out_q_reg       <= '0;
      skid_q_reg      <= '0;
    end else begin
      rd_ptr_reg      <= rd_ptr_next;
      // Gray taken from the next binary value so it stays aligned with rd_ptr_reg.
      rd_ptr_gray_reg <= PW'(bin2gray(ptr_word_t'(rd_ptr_next)));
      out_vld_reg     <= out_vld_next;
      skid_vld_reg    <= skid_vld_next;
      inflight_reg    <= mem_rd_en;
      out_q_reg       <= out_q_next;
      skid_q_reg      <= skid_q_next;
    end
  end

  assign level       = LW'(mem_level) + LW'(occ);
  assign rd_addr     = rd_ptr_reg[PTR_WIDTH-1:0];
  assign rd_ptr_gray = rd_ptr_gray_reg;

  assign rd_if.dout         = out_q_reg;
  assign rd_if.dout_valid   = out_vld_reg;
  assign rd_if.empty        = ~out_vld_reg;
  assign rd_if.rd_level     = level;
  assign rd_if.almost_empty = (level <= LW'(ALMOST_EMPTY_GAP));

endmodule

// File: tb/tb_rd_empty_fwft.sv
// Directed bench for rd_empty_fwft: a wide instance for latency/throughput/ordering
// and a 3-bit-pointer instance for wrap-around.
module tb_rd_empty_fwft;

  logic rd_clk;
  logic rd_rst;

  // Instance A: PTR_WIDTH = 8
  logic [8:0]  a_wgray;
  logic [15:0] a_mem_rd_data;
  logic        a_mem_rd_en;
  logic [7:0]  a_rd_addr;
  logic [8:0]  a_rd_ptr_gray;
  logic [15:0] mem_a [256];
  logic [8:0]  wptr_a;

  // Instance B: PTR_WIDTH = 3
  logic [3:0]  b_wgray;
  logic [15:0] b_mem_rd_data;
  logic        b_mem_rd_en;
  logic [2:0]  b_rd_addr;
  logic [3:0]  b_rd_ptr_gray;
  logic [15:0] mem_b [8];
  logic [3:0]  wptr_b;

  int checks = 0;
  int errors = 0;

  rd_empty_fwft_if #(.DATA_WIDTH(16), .PTR_WIDTH(8)) a_if ();
  rd_empty_fwft_if #(.DATA_WIDTH(16), .PTR_WIDTH(3)) b_if ();

  rd_empty_fwft #(.DATA_WIDTH(16), .PTR_WIDTH(8), .ALMOST_EMPTY_GAP(3), .SYNC_STAGES(2)) u_dut_a (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .w_ptr_gray  (a_wgray),
    .mem_rd_data (a_mem_rd_data),
    .mem_rd_en   (a_mem_rd_en),
    .rd_addr     (a_rd_addr),
    .rd_ptr_gray (a_rd_ptr_gray),
    .rd_if       (a_if.master)
  );

  rd_empty_fwft #(.DATA_WIDTH(16), .PTR_WIDTH(3), .ALMOST_EMPTY_GAP(3), .SYNC_STAGES(2)) u_dut_b (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .w_ptr_gray  (b_wgray),
    .mem_rd_data (b_mem_rd_data),
    .mem_rd_en   (b_mem_rd_en),
    .rd_addr     (b_rd_addr),
    .rd_ptr_gray (b_rd_ptr_gray),
    .rd_if       (b_if.master)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // 1-cycle latency memory models
  initial a_mem_rd_data = '0;
  initial b_mem_rd_data = '0;
  always @(posedge rd_clk) if (a_mem_rd_en) a_mem_rd_data <= mem_a[a_rd_addr];
  always @(posedge rd_clk) if (b_mem_rd_en) b_mem_rd_data <= mem_b[b_rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [15:0] d);
    mem_a[wptr_a[7:0]] = d;
    wptr_a  = wptr_a + 9'd1;
    a_wgray = wptr_a ^ (wptr_a >> 1);
  endtask

  function automatic logic [3:0] g2b4(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int fetches;
    int idx;
    int got;
    int sent;
    int wraps;
    int seen;
    logic [15:0] pat;
    logic [3:0]  prev_gray;
    logic [3:0]  rbin;

    rd_rst = 1'b1;
    a_wgray = '0; wptr_a = '0; a_if.rd_en = 1'b0;
    b_wgray = '0; wptr_b = '0; b_if.rd_en = 1'b0;

    // 1: reset and idle
    repeat (3) @(negedge rd_clk);
    check("rst_empty", 32'(a_if.empty), 32'd1);
    check("rst_almost_empty", 32'(a_if.almost_empty), 32'd1);
    check("rst_level", 32'(a_if.rd_level), 32'd0);
    check("rst_mem_rd_en", 32'(a_mem_rd_en), 32'd0);
    check("rst_b_empty", 32'(b_if.empty), 32'd1);
    check("rst_b_almost_empty", 32'(b_if.almost_empty), 32'd1);
    rd_rst = 1'b0;
    repeat (6) @(negedge rd_clk);
    check("idle_empty", 32'(a_if.empty), 32'd1);
    check("idle_level", 32'(a_if.rd_level), 32'd0);
    check("idle_mem_rd_en", 32'(a_mem_rd_en), 32'd0);
    check("idle_b_level", 32'(b_if.rd_level), 32'd0);

    // 2: single word latency and pop
    push_a(16'hA5A5);
    lat = 0;
    while (!a_if.dout_valid && lat < 12) begin
      @(negedge rd_clk);
      lat++;
    end
    check("t2_latency", 32'(lat), 32'd4);
    check("t2_dout", 32'(a_if.dout), 32'hA5A5);
    check("t2_level", 32'(a_if.rd_level), 32'd1);
    check("t2_almost_empty", 32'(a_if.almost_empty), 32'd1);
    a_if.rd_en = 1'b1;
    @(negedge rd_clk);
    a_if.rd_en = 1'b0;
    check("t2_empty_after_pop", 32'(a_if.empty), 32'd1);
    check("t2_rd_ptr_gray", 32'(a_rd_ptr_gray), 32'd1);
    check("t2_level_after_pop", 32'(a_if.rd_level), 32'd0);

    // 3: streaming with rd_en held high
    for (int i = 0; i < 10; i++) push_a(16'(i));
    a_if.rd_en = 1'b1;
    lat = 0;
    while (!a_if.dout_valid && lat < 12) begin
      @(negedge rd_clk);
      lat++;
    end
    check("t3_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      check("t3_valid", 32'(a_if.dout_valid), 32'd1);
      check("t3_dout", 32'(a_if.dout), 32'(i));
      check("t3_level", 32'(a_if.rd_level), 32'(10 - i));
      check("t3_almost_empty", 32'(a_if.almost_empty), ((10 - i) <= 3) ? 32'd1 : 32'd0);
      @(negedge rd_clk);
    end
    a_if.rd_en = 1'b0;
    check("t3_drained_empty", 32'(a_if.empty), 32'd1);
    check("t3_drained_level", 32'(a_if.rd_level), 32'd0);

    // 4: back-pressure then irregular pops
    for (int i = 0; i < 10; i++) push_a(16'(100 + i));
    fetches = 0;
    repeat (8) begin
      @(negedge rd_clk);
      if (a_mem_rd_en) fetches++;
    end
    check("t4_fetches", 32'(fetches), 32'd2);
    check("t4_valid", 32'(a_if.dout_valid), 32'd1);
    check("t4_head", 32'(a_if.dout), 32'd100);
    check("t4_level", 32'(a_if.rd_level), 32'd10);
    check("t4_stalled_mem_rd_en", 32'(a_mem_rd_en), 32'd0);
    pat = 16'b1011_0010_1110_0101;
    idx = 0;
    for (int c = 0; c < 80 && idx < 10; c++) begin
      a_if.rd_en = pat[c % 16];
      if (a_if.rd_en && a_if.dout_valid) begin
        check("t4_order", 32'(a_if.dout), 32'(100 + idx));
        idx++;
      end
      @(negedge rd_clk);
    end
    a_if.rd_en = 1'b0;
    check("t4_count", 32'(idx), 32'd10);
    check("t4_drained_empty", 32'(a_if.empty), 32'd1);
    check("t4_drained_level", 32'(a_if.rd_level), 32'd0);

    // 5: wrap-around on the 3-bit-pointer instance
    b_if.rd_en = 1'b1;
    sent = 0; got = 0; wraps = 0;
    prev_gray = b_rd_ptr_gray;
    for (int c = 0; c < 400 && got < 40; c++) begin
      if (b_if.dout_valid) begin
        check("t5_data", 32'(b_if.dout), 32'(16'h1000 + got));
        got++;
      end
      if (b_rd_ptr_gray != prev_gray) begin
        check("t5_gray_1bit", 32'($countones(b_rd_ptr_gray ^ prev_gray)), 32'd1);
        if (b_rd_ptr_gray == 4'd0) wraps++;
        prev_gray = b_rd_ptr_gray;
      end
      rbin = g2b4(b_rd_ptr_gray);
      if (sent < 40 && 4'(wptr_b - rbin) < 4'd8) begin
        mem_b[wptr_b[2:0]] = 16'(16'h1000 + sent);
        wptr_b  = wptr_b + 4'd1;
        b_wgray = wptr_b ^ (wptr_b >> 1);
        sent++;
      end
      @(negedge rd_clk);
    end
    b_if.rd_en = 1'b0;
    check("t5_count", 32'(got), 32'd40);
    check("t5_wraps", 32'(wraps), 32'd2);
    check("t5_b_empty", 32'(b_if.empty), 32'd1);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push_a(16'(16'h5000 + i));
    repeat (4) @(negedge rd_clk);
    check("t6_pre_valid", 32'(a_if.dout_valid), 32'd1);
    check("t6_pre_level", 32'(a_if.rd_level), 32'd5);
    #2;
    rd_rst = 1'b1;
    wptr_a = '0; a_wgray = '0;
    wptr_b = '0; b_wgray = '0;
    #1;
    check("t6_rst_empty", 32'(a_if.empty), 32'd1);
    check("t6_rst_dout", 32'(a_if.dout), 32'd0);
    check("t6_rst_level", 32'(a_if.rd_level), 32'd0);
    check("t6_rst_almost_empty", 32'(a_if.almost_empty), 32'd1);
    check("t6_rst_mem_rd_en", 32'(a_mem_rd_en), 32'd0);
    check("t6_rst_gray", 32'(a_rd_ptr_gray), 32'd0);
    @(negedge rd_clk);
    rd_rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge rd_clk);
      if (a_if.dout_valid) seen++;
    end
    check("t6_no_stale_word", 32'(seen), 32'd0);
    check("t6_post_level", 32'(a_if.rd_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
